mul_div_unit: RTL and testbench

Multi-cycle multiply/divide unit that computes 64-bit products and quotient/remainder pairs into architectural HI/LO registers. It sits beside the ALU in the datapath, takes its operands from the register-file read ports (rs, rt), and produces the HI/LO values consumed by the mfhi/mflo result mux. It replaces the single-cycle combinational product with an iterative radix-2 engine and raises `busy` so control can stall the pipeline.

---
 rtl/mdu_pkg.sv | 20 ++
 rtl/mdu_negate.sv | 12 +
 rtl/mul_div_unit.sv | 148 ++++++++++++++
 tb/tb_mul_div_unit.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// FSM state enum and default operand width.
package mdu_pkg;

  localparam int unsigned MDU_WIDTH = 32;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    SIGN = 2'b10
  } mdu_state_e;

endpackage

// File: rtl/mdu_negate.sv
// Conditional two's-complement: out = en ? -in : in.
module mdu_negate #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             en,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out
);

  assign out = en ? ('0 - in) : in;

endmodule

// File: rtl/mul_div_unit.sv
// Iterative radix-2 multiply/divide unit writing architectural HI/LO.
// Divider datapath and DIV/DIVU ops are only built when MDU_DIV_EN is defined.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wd,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  mdu_state_e         state, state_nxt;
  mdu_op_e            op_e;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_step;
  logic [2*WIDTH-1:0] mul_step;
  logic [WIDTH:0]     add_sum;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH-1:0]   res_hi, res_lo;
  logic               neg_res;
  logic               accept;
  logic               signed_op, sign_a, sign_b;

  assign op_e      = mdu_op_e'(op);
  assign signed_op = (op_e == MDU_MULT) || (op_e == MDU_DIV);
  assign sign_a    = signed_op & a[WIDTH-1];
  assign sign_b    = signed_op & b[WIDTH-1];
  assign busy      = (state != IDLE);

  mdu_negate #(.WIDTH(WIDTH)) u_abs_a (.en(sign_a), .in(a), .out(abs_a));
  mdu_negate #(.WIDTH(WIDTH)) u_abs_b (.en(sign_b), .in(b), .out(abs_b));
  mdu_negate #(.WIDTH(2*WIDTH)) u_neg_prod (.en(neg_res), .in(acc), .out(prod_fix));

  // Shift-add: acc holds {partial product, remaining multiplier bits}.
  assign add_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mcand & {WIDTH{acc[0]}}};
  assign mul_step = {add_sum, acc[WIDTH-1:1]};

`ifdef MDU_DIV_EN
  logic               is_div, neg_rem;
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH-1:0] div_step;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign accept = start;

  // Restoring divide: acc holds {remainder, dividend/quotient bits}.
  assign div_trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, mcand};
  assign div_step  = div_trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                      : {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
  assign acc_step  = is_div ? div_step : mul_step;

  mdu_negate #(.WIDTH(WIDTH)) u_neg_quo (.en(neg_res), .in(acc[WIDTH-1:0]), .out(quo_fix));
  mdu_negate #(.WIDTH(WIDTH)) u_neg_rem (.en(neg_rem), .in(acc[2*WIDTH-1:WIDTH]), .out(rem_fix));

  assign res_hi = is_div ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
  assign res_lo = is_div ? quo_fix : prod_fix[WIDTH-1:0];
`else
  assign accept   = start && ((op_e == MDU_MULT) || (op_e == MDU_MULTU));
  assign acc_step = mul_step;
  assign res_hi   = prod_fix[2*WIDTH-1:WIDTH];
  assign res_lo   = prod_fix[WIDTH-1:0];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = CALC;
      CALC:    if (cnt == CW'(1)) state_nxt = SIGN;
      SIGN:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      mcand   <= '0;
      acc     <= '0;
      neg_res <= 1'b0;
`ifdef MDU_DIV_EN
      is_div  <= 1'b0;
      neg_rem <= 1'b0;
`endif
    end else if (state == IDLE && accept) begin
      cnt     <= CW'(WIDTH);
      neg_res <= sign_a ^ sign_b;
`ifdef MDU_DIV_EN
      is_div  <= op[1];
      neg_rem <= sign_a;
      if (op[1]) begin
        // Zero divisor must leave the all-ones quotient un-negated.
        neg_res <= (sign_a ^ sign_b) && (b != '0);
        mcand   <= abs_b;
        acc     <= {{WIDTH{1'b0}}, abs_a};
      end else begin
        mcand   <= abs_a;
        acc     <= {{WIDTH{1'b0}}, abs_b};
      end
`else
      mcand   <= abs_a;
      acc     <= {{WIDTH{1'b0}}, abs_b};
`endif
    end else if (state == CALC) begin
      cnt <= cnt - CW'(1);
      acc <= acc_step;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi   <= '0;
      lo   <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == SIGN) begin
        hi   <= res_hi;
        lo   <= res_lo;
        done <= 1'b1;
      end else if (state == IDLE) begin
        if (hi_we) hi <= wd;
        if (lo_we) lo <= wd;
      end
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed vector table, random ops
// against a plain-arithmetic reference model, and multi-cycle corner sequences.
module tb_mul_div_unit;
  import mdu_pkg::*;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst, start, hi_we, lo_we, busy, done;
  logic [1:0]   op;
  logic [W-1:0] a, b, wd, hi, lo;

  int n_checks = 0;
  int n_fail   = 0;

  mul_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wd(wd),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } vec_t;

  vec_t tbl[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void ref_model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                    output logic [W-1:0] eh, output logic [W-1:0] el);
    longint       sx, sy;
    logic [63:0]  p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      2'b00:   p = 64'(sx * sy);
      2'b01:   p = {32'd0, x} * {32'd0, y};
      2'b10:   p = (y == 0) ? {x, 32'hFFFF_FFFF} : {32'(sx % sy), 32'(sx / sy)};
      default: p = (y == 0) ? {x, 32'hFFFF_FFFF} : {x % y, x / y};
    endcase
    eh = p[63:32];
    el = p[31:0];
  endfunction

  task automatic do_op(input string name, input logic [1:0] o, input logic [W-1:0] x,
                       input logic [W-1:0] y, input logic [W-1:0] eh, input logic [W-1:0] el);
    logic         accepted;
    logic         bad;
    int           n;
    logic [W-1:0] hi0, lo0;
`ifdef MDU_DIV_EN
    accepted = 1'b1;
`else
    accepted = !o[1];
`endif
    op = o; a = x; b = y; start = 1'b1;
    step();
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    a = $urandom; b = $urandom;
    check({name, " done_pulse_ended"}, done, 0);
    if (accepted) begin
      check({name, " busy_after_start"}, busy, 1);
      n = 0; bad = 1'b0;
      while (!done && n < 60) begin
        if (!busy) bad = 1'b1;
        step();
        n++;
      end
      check({name, " latency"}, n, W + 1);
      check({name, " busy_held"}, bad, 0);
      check({name, " hi"}, hi, eh);
      check({name, " lo"}, lo, el);
      check({name, " busy_clear_at_done"}, busy, 0);
    end else begin
      hi0 = hi; lo0 = lo;
      check({name, " ignored_busy"}, busy, 0);
      bad = 1'b0;
      repeat (W + 4) begin
        if (done || busy) bad = 1'b1;
        step();
      end
      check({name, " ignored_no_done"}, bad, 0);
      check({name, " ignored_hi"}, hi, hi0);
      check({name, " ignored_lo"}, lo, lo0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] eh, el, x, y;
    logic [1:0]   o;
    logic         bad;
    int           n;

    tbl[0]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    tbl[1]  = '{2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
    tbl[2]  = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    tbl[3]  = '{2'b11, 32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF};
    tbl[4]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    tbl[5]  = '{2'b10, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFF};
    tbl[6]  = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    tbl[7]  = '{2'b00, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
    tbl[8]  = '{2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    tbl[9]  = '{2'b01, 32'h0000_0000, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000};
    tbl[10] = '{2'b11, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF};

    rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
    hi_we = 1'b0; lo_we = 1'b0; wd = '0;
    #2;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_hi", hi, 0);
    check("reset_lo", lo, 0);
    step(); step();
    rst = 1'b0;
    step();

    // mthi/mtlo in IDLE
    hi_we = 1'b1; lo_we = 1'b1; wd = 32'hCAFE_F00D;
    step();
    hi_we = 1'b0; lo_we = 1'b0;
    check("mthi_idle", hi, 32'hCAFE_F00D);
    check("mtlo_idle", lo, 32'hCAFE_F00D);

    for (int i = 0; i < 11; i++)
      do_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].hi, tbl[i].lo);

    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      x = $urandom;
      y = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) y = y & 32'h0000_00FF;
      ref_model(o, x, y, eh, el);
      do_op($sformatf("rnd%0d", i), o, x, y, eh, el);
    end

    // mthi/mtlo in the same cycle as start: the result overwrites them
    hi_we = 1'b1; lo_we = 1'b1; wd = 32'hDEAD_BEEF;
    do_op("wr_with_start", 2'b01, 32'd6, 32'd7, 32'd0, 32'd42);

    // second start and mthi while busy are ignored
    hi_we = 1'b1; wd = 32'hAAAA_5555;
    step();
    hi_we = 1'b0;
    check("mthi_before_busy", hi, 32'hAAAA_5555);
    op = 2'b01; a = 32'd4; b = 32'd5; start = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    op = 2'b01; a = 32'd2; b = 32'd3; start = 1'b1; hi_we = 1'b1; wd = 32'h0000_1234;
    step();
    start = 1'b0; hi_we = 1'b0;
    check("busy_restart_busy", busy, 1);
    check("busy_mthi_ignored", hi, 32'hAAAA_5555);
    n = 0;
    while (!done && n < 60) begin
      step();
      n++;
    end
    check("busy_restart_latency", n, W - 4);
    check("busy_restart_lo", lo, 32'd20);
    check("busy_restart_hi", hi, 32'd0);

    // reset mid-operation aborts with no done
    hi_we = 1'b1; lo_we = 1'b1; wd = 32'h5A5A_A5A5;
    step();
    hi_we = 1'b0; lo_we = 1'b0;
`ifdef MDU_DIV_EN
    op = 2'b11;
`else
    op = 2'b01;
`endif
    a = 32'd100; b = 32'd7; start = 1'b1;
    step();
    start = 1'b0;
    repeat (9) step();
    check("abort_busy_before", busy, 1);
    rst = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_hi", hi, 0);
    check("abort_lo", lo, 0);
    check("abort_done", done, 0);
    step();
    rst = 1'b0;
    bad = 1'b0;
    repeat (W + 6) begin
      step();
      if (done || busy) bad = 1'b1;
    end
    check("abort_no_done", bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
